// File: rtl/looper_pkg.sv
// Shared types and defaults for the looper transport controller.
package looper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RECORD = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSE  = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_STOP,
    CMD_REC,
    CMD_PLAY
  } cmd_t;

  localparam int SPEED_MAX_UP_DEF   = 2;
  localparam int SPEED_MAX_DOWN_DEF = 4;

  // Transport events collapse to one command: stop beats rec beats play.
  function automatic cmd_t pick_cmd(input logic stop, input logic rec, input logic play);
    if (stop)      return CMD_STOP;
    else if (rec)  return CMD_REC;
    else if (play) return CMD_PLAY;
    else           return CMD_NONE;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// One-cycle pulse on the rising edge of a synchronous level input.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/looper_controller.sv
// Transport/speed controller for a sample looper: button events drive the
// record/play/pause FSM, loop length counting, direction and speed steps.
module looper_controller
  import looper_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int SPEED_MAX_UP   = SPEED_MAX_UP_DEF,
  parameter int SPEED_MAX_DOWN = SPEED_MAX_DOWN_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_rec,
  input  logic                  btn_play,
  input  logic                  btn_stop,
  input  logic                  btn_rev,
  input  logic                  btn_fast,
  input  logic                  btn_slow,
  input  logic                  sample_tick,
  output logic                  write,
  output logic                  read,
  output logic                  reverse,
  output logic                  speedUpRecording,
  output logic                  slowDownRecording,
  output logic [2:0]            state,
  output logic [ADDR_WIDTH:0]   loop_len,
  output logic signed [3:0]     speed_level
);

  localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] LEN_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic signed [3:0]   UP_LIM   = 4'(SPEED_MAX_UP);
  localparam logic signed [3:0]   DN_LIM   = 4'(-SPEED_MAX_DOWN);

  logic [5:0] btn_level;
  logic [5:0] btn_event;

  assign btn_level = {btn_slow, btn_fast, btn_rev, btn_stop, btn_play, btn_rec};

  for (genvar i = 0; i < 6; i++) begin : g_edge
    edge_pulse u_edge (
      .clk   (clk),
      .reset (reset),
      .level (btn_level[i]),
      .pulse (btn_event[i])
    );
  end

  logic ev_rec, ev_play, ev_stop, ev_rev, ev_fast, ev_slow;
  assign {ev_slow, ev_fast, ev_rev, ev_stop, ev_play, ev_rec} = btn_event;

  state_t           cur_state, nxt_state;
  cmd_t             cmd;
  logic             len_clear, len_inc, len_nz;
  logic             rev_d, up_d, dn_d;
  logic signed [3:0] speed_d;

  assign len_nz = (loop_len != '0);
  assign state  = cur_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_state <= ST_IDLE;
    else        cur_state <= nxt_state;
  end

  // A transport event in RECORD takes precedence over a same-cycle sample tick.
  always_comb begin
    nxt_state = cur_state;
    len_clear = 1'b0;
    len_inc   = 1'b0;
    cmd       = pick_cmd(ev_stop, ev_rec, ev_play);
    case (cur_state)
      ST_IDLE: begin
        if (cmd == CMD_REC) begin
          nxt_state = ST_RECORD;
          len_clear = 1'b1;
        end
      end
      ST_RECORD: begin
        if (cmd == CMD_STOP) begin
          nxt_state = len_nz ? ST_PAUSE : ST_IDLE;
        end else if (cmd == CMD_REC || cmd == CMD_PLAY) begin
          nxt_state = len_nz ? ST_PLAY : ST_IDLE;
        end else if (sample_tick) begin
          len_inc = 1'b1;
          if (loop_len == LEN_LAST) nxt_state = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (cmd == CMD_STOP) begin
          nxt_state = ST_PAUSE;
        end else if (cmd == CMD_REC) begin
          nxt_state = ST_RECORD;
          len_clear = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (cmd == CMD_REC) begin
          nxt_state = ST_RECORD;
          len_clear = 1'b1;
        end else if (cmd == CMD_PLAY) begin
          nxt_state = ST_PLAY;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    rev_d   = reverse;
    speed_d = speed_level;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    if (len_clear) begin
      rev_d = 1'b0;
    end else if (ev_rev && (cur_state == ST_PLAY || cur_state == ST_PAUSE)) begin
      rev_d = ~reverse;
    end
    if (cur_state != ST_RECORD && (ev_fast ^ ev_slow)) begin
      if (ev_fast && speed_level < UP_LIM) begin
        speed_d = speed_level + 4'sd1;
        up_d    = 1'b1;
      end
      if (ev_slow && speed_level > DN_LIM) begin
        speed_d = speed_level - 4'sd1;
        dn_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write             <= 1'b0;
      read              <= 1'b0;
      reverse           <= 1'b0;
      speedUpRecording  <= 1'b0;
      slowDownRecording <= 1'b0;
      speed_level       <= 4'sd0;
      loop_len          <= '0;
    end else begin
      write             <= (nxt_state == ST_RECORD);
      read              <= (nxt_state == ST_PLAY);
      reverse           <= rev_d;
      speedUpRecording  <= up_d;
      slowDownRecording <= dn_d;
      speed_level       <= speed_d;
      if (len_clear)    loop_len <= '0;
      else if (len_inc) loop_len <= loop_len + LEN_ONE;
    end
  end

endmodule

// File: tb/tb_looper_controller.sv
// Bench for looper_controller: directed scenarios plus randomized button/tick
// traffic checked cycle by cycle against a behavioural model.
module tb_looper_controller;

  localparam int AW = 4;
  localparam int MAX_LEN = 1 << AW;
  localparam int M_IDLE = 0, M_RECORD = 1, M_PLAY = 2, M_PAUSE = 3;
  localparam logic [5:0] B_REC = 6'b000001, B_PLAY = 6'b000010, B_STOP = 6'b000100,
                         B_REV = 6'b001000, B_FAST = 6'b010000, B_SLOW = 6'b100000;

  logic clk = 1'b0;
  logic reset;
  logic btn_rec, btn_play, btn_stop, btn_rev, btn_fast, btn_slow, sample_tick;
  logic write, read, reverse, speedUpRecording, slowDownRecording;
  logic [2:0] state;
  logic [AW:0] loop_len;
  logic signed [3:0] speed_level;

  always #5 clk = ~clk;

  looper_controller #(.ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .btn_rec           (btn_rec),
    .btn_play          (btn_play),
    .btn_stop          (btn_stop),
    .btn_rev           (btn_rev),
    .btn_fast          (btn_fast),
    .btn_slow          (btn_slow),
    .sample_tick       (sample_tick),
    .write             (write),
    .read              (read),
    .reverse           (reverse),
    .speedUpRecording  (speedUpRecording),
    .slowDownRecording (slowDownRecording),
    .state             (state),
    .loop_len          (loop_len),
    .speed_level       (speed_level)
  );

  int checks = 0;
  int failures = 0;
  int up_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: the looper's observable transport/speed rules.
  logic [5:0] m_prev;
  int m_state, m_len, m_speed;
  bit m_rev, m_up, m_dn;

  task automatic model_reset();
    m_prev = '0; m_state = M_IDLE; m_len = 0; m_speed = 0;
    m_rev = 0; m_up = 0; m_dn = 0;
  endtask

  task automatic model_step(input logic [5:0] b, input logic tick);
    logic [5:0] ev;
    int old;
    bit new_loop;
    ev = b & ~m_prev;
    m_prev = b;
    old = m_state;
    new_loop = 0;
    if (ev[2]) begin
      if (old == M_PLAY) m_state = M_PAUSE;
      else if (old == M_RECORD) m_state = (m_len > 0) ? M_PAUSE : M_IDLE;
    end else if (ev[0]) begin
      if (old == M_RECORD) m_state = (m_len > 0) ? M_PLAY : M_IDLE;
      else new_loop = 1;
    end else if (ev[1]) begin
      if (old == M_RECORD) m_state = (m_len > 0) ? M_PLAY : M_IDLE;
      else if (old == M_PAUSE) m_state = M_PLAY;
    end else if (old == M_RECORD && tick) begin
      m_len++;
      if (m_len == MAX_LEN) m_state = M_PLAY;
    end
    if (new_loop) begin
      m_state = M_RECORD; m_len = 0; m_rev = 0;
    end else if (ev[3] && (old == M_PLAY || old == M_PAUSE)) begin
      m_rev = !m_rev;
    end
    m_up = 0; m_dn = 0;
    if (old != M_RECORD && ev[4] && !ev[5] && m_speed < 2) begin
      m_speed++; m_up = 1;
    end
    if (old != M_RECORD && ev[5] && !ev[4] && m_speed > -4) begin
      m_speed--; m_dn = 1;
    end
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".state"}, 32'(state), 32'(m_state));
    check({ctx, ".loop_len"}, 32'(loop_len), 32'(m_len));
    check({ctx, ".speed"}, {28'd0, speed_level}, {28'd0, m_speed[3:0]});
    check({ctx, ".reverse"}, 32'(reverse), 32'(m_rev));
    check({ctx, ".write"}, 32'(write), 32'(m_state == M_RECORD));
    check({ctx, ".read"}, 32'(read), 32'(m_state == M_PLAY));
    check({ctx, ".up"}, 32'(speedUpRecording), 32'(m_up));
    check({ctx, ".dn"}, 32'(slowDownRecording), 32'(m_dn));
  endtask

  // Drive at negedge, let one rising edge act, then compare 1 ns later.
  task automatic step(input logic [5:0] b, input logic tick, input string ctx);
    {btn_slow, btn_fast, btn_rev, btn_stop, btn_play, btn_rec} = b;
    sample_tick = tick;
    @(posedge clk);
    model_step(b, tick);
    #1;
    if (speedUpRecording) up_count++;
    compare_all(ctx);
    @(negedge clk);
  endtask

  task automatic press(input logic [5:0] b, input string ctx);
    step(b, 1'b0, ctx);
    step(6'b0, 1'b0, ctx);
  endtask

  task automatic do_reset();
    {btn_slow, btn_fast, btn_rev, btn_stop, btn_play, btn_rec} = '0;
    sample_tick = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [5:0] rb;
    reset = 1'b0;
    {btn_slow, btn_fast, btn_rev, btn_stop, btn_play, btn_rec} = '0;
    sample_tick = 1'b0;
    @(negedge clk);
    do_reset();

    // record 5 samples then play
    press(B_REC, "rec5");
    for (int i = 0; i < 5; i++) begin
      step(6'b0, 1'b1, "rec5");
      step(6'b0, 1'b0, "rec5");
    end
    press(B_PLAY, "rec5");
    check("rec5_state_play", 32'(state), 32'(M_PLAY));
    check("rec5_len", 32'(loop_len), 32'd5);
    check("rec5_read", 32'(read), 32'd1);
    check("rec5_write", 32'(write), 32'd0);

    // fill the loop: auto play on the last sample, no wrap afterwards
    do_reset();
    press(B_REC, "full");
    for (int i = 0; i < MAX_LEN - 1; i++) step(6'b0, 1'b1, "full");
    check("full_still_rec", 32'(state), 32'(M_RECORD));
    step(6'b0, 1'b1, "full");
    check("full_auto_play", 32'(state), 32'(M_PLAY));
    check("full_len", 32'(loop_len), 32'(MAX_LEN));
    step(6'b0, 1'b1, "full");
    check("full_len_hold", 32'(loop_len), 32'(MAX_LEN));

    // empty recording aborts to idle
    do_reset();
    step(B_REC, 1'b0, "empty");
    step(6'b0, 1'b0, "empty");
    press(B_STOP, "empty");
    check("empty_idle", 32'(state), 32'(M_IDLE));
    check("empty_len", 32'(loop_len), 32'd0);
    check("empty_write", 32'(write), 32'd0);

    // speed clamps in PLAY
    press(B_REC, "speed");
    for (int i = 0; i < 3; i++) step(6'b0, 1'b1, "speed");
    press(B_PLAY, "speed");
    up_count = 0;
    for (int i = 0; i < 3; i++) press(B_FAST, "fast");
    check("fast_pulses", 32'(up_count), 32'd2);
    check("fast_level", {28'd0, speed_level}, 32'h2);
    for (int i = 0; i < 5; i++) press(B_SLOW, "slow");
    check("slow_level", {28'd0, speed_level}, 32'hd);
    press(B_FAST | B_SLOW, "both");
    check("both_level", {28'd0, speed_level}, 32'hd);

    // stop beats play; held rev toggles once
    press(B_STOP | B_PLAY, "prio");
    check("prio_pause", 32'(state), 32'(M_PAUSE));
    press(B_PLAY, "prio");
    for (int i = 0; i < 20; i++) step(B_REV, 1'b0, "rev");
    step(6'b0, 1'b0, "rev");
    check("rev_once", 32'(reverse), 32'd1);

    // asynchronous reset mid-record
    press(B_REC, "async");
    step(6'b0, 1'b1, "async");
    step(6'b0, 1'b1, "async");
    check("async_writing", 32'(write), 32'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_len", 32'(loop_len), 32'd0);
    check("async_write", 32'(write), 32'd0);
    check("async_read", 32'(read), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(6'b0, 1'b0, "async_rel");

    // randomized traffic
    rb = '0;
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 6; k++)
        if ($urandom_range(0, 5) == 0) rb[k] = ~rb[k];
      if ($urandom_range(0, 9) == 0) rb = '0;
      step(rb, 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        rb = '0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
